ram_steuerung: RTL and testbench
================================

# ram_steuerung

Memory-side controller between the cache's RAM port and an external 16-bit asynchronous SRAM. It accepts one 32-bit word read or write request at a time from the cache (`RAMLesen`/`RAMSchreiben`, `RAMAdresse`, `RAMSchreibDaten`). It performs the request as two 16-bit SRAM accesses with programmable wait states, then returns `RAMLesDaten` and a one-cycle `RAMDatenGeladen`/`RAMDatenGelesen` acknowledge. All cache-facing port names match the cache's RAM-side ports one-to-one.

## Interface
Parameters:
- `ADRBITS`, 19: SRAM half-word address width; the controller covers byte addresses `0 .. 2^(ADRBITS+1)-1`.
- `WARTEZYKLEN`, 2: wait cycles per half-word access; legal range 1..15.

Ports:
- `Takt` in 1: the single clock; all state changes on its rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `RAMLesen` in 1: read request; a level held by the cache until acknowledged.
- `RAMSchreiben` in 1: write request; a level held by the cache until acknowledged.
- `RAMAdresse` in 32: byte address; bits [1:0] ignored; bits above `ADRBITS` ignored.
- `RAMSchreibDaten` in 32: write word.
- `RAMLesDaten` out 32: read word; registered.
- `RAMDatenGeladen` out 1: one-cycle pulse; the read is complete and `RAMLesDaten` is valid.
- `RAMDatenGelesen` out 1: one-cycle pulse; the write is complete.
- `SramAdresse` out `ADRBITS`: half-word address.
- `SramDatenAus` out 16: write data to the pads.
- `SramDatenEin` in 16: read data from the pads.
- `SramDatenAusAktiv` out 1: pad output enable; the tristate buffer lives at top level.
- `SramCE_n`, `SramOE_n`, `SramWE_n` out 1 each: active-low chip enable, output enable and write enable.

## Operation
- Address mapping: `SramAdresse = {RAMAdresse[ADRBITS:2], hw}`.
  - `hw=0` carries word bits [15:0]; `hw=1` carries bits [31:16] (little-endian).
- FSM states: `LEERLAUF`, `LESEN_NIEDRIG`, `LESEN_HOCH`, `SCHREIBEN_NIEDRIG`, `SCHREIBEN_HOCH`, `FERTIG`, `ERHOLUNG`.
- `LEERLAUF`:
  - Samples the requests.
  - `RAMSchreiben` high → latch address and data, go to `SCHREIBEN_NIEDRIG`.
  - Otherwise `RAMLesen` high → latch address, go to `LESEN_NIEDRIG`.
  - Both high → the write wins; the read is served on a later pass because the cache still holds it.
- Each NIEDRIG/HOCH phase lasts exactly `WARTEZYKLEN+1` cycles, counted by a phase counter cleared on entry.
  - `SramCE_n` is low in every phase cycle.
  - `SramAdresse` is stable for the whole phase.
- Read phase:
  - `SramOE_n` is low for all phase cycles.
  - `SramDatenEin` is captured at the edge that ends the phase.
  - NIEDRIG captures into bits [15:0], HOCH into bits [31:16] of an internal buffer.
  - `RAMLesDaten` loads the full buffer on entry to `FERTIG`.
- Write phase:
  - `SramDatenAusAktiv` is high and `SramDatenAus` is stable for all phase cycles.
  - `SramWE_n` is low for the first `WARTEZYKLEN` cycles and high in the last cycle, which provides data hold.
- `FERTIG` (one cycle):
  - `RAMDatenGeladen` (read) or `RAMDatenGelesen` (write) is high.
  - All SRAM strobes are inactive.
- `ERHOLUNG` (one cycle):
  - Requests are ignored, giving the cache one cycle to drop its request.
  - Then the FSM returns to `LEERLAUF`.
- `RAMLesDaten` holds its value until the next read completes; writes never change it.
- Only one request is in flight at a time; no queueing.

## Timing
- Reset values:
  - `RAMLesDaten=0`, both acknowledges 0.
  - `SramCE_n=SramOE_n=SramWE_n=1`, `SramDatenAusAktiv=0`.
  - `SramAdresse=0`, `SramDatenAus=0`.
  - State `LEERLAUF`.
- Latency: with the request sampled at edge E, the acknowledge is high in the cycle after edge `E + 2*(WARTEZYKLEN+1) + 1`.
  - This is 7 cycles for `WARTEZYKLEN=2` and 5 cycles for `WARTEZYKLEN=1`.
- Throughput: a new request is accepted no earlier than 2 cycles after the acknowledge cycle.
- All outputs are registered; SRAM strobes are glitch-free.
- Reset asserted mid-access: all strobes go inactive immediately (asynchronously); no acknowledge is issued; the in-flight request is dropped.
- A request dropped by the cache before its acknowledge is still completed and acknowledged; the acknowledge is then ignored.
- Address bits above `ADRBITS` are discarded silently (the address wraps).

## Test plan
- Reset → every output at its listed reset value; held through 5 clocks with requests low.
- Write `0xDEADBEEF` to `0x00000104`, `WARTEZYKLEN=2`:
  - SRAM sees 0x082←`0xBEEF` then 0x083←`0xDEAD`.
  - `SramWE_n` low 2 of 3 cycles in each phase.
  - `RAMDatenGelesen` high exactly once, 7 cycles after sampling.
- Read `0x00000104` with an SRAM model returning the contents above → `RAMDatenGeladen` pulse after 7 cycles, `RAMLesDaten=0xDEADBEEF`; the value holds through a following write.
- `RAMLesen` and `RAMSchreiben` both high, held until each acknowledge → write performed first, read second; two acknowledges total, none duplicated.
- Request held high for 1 cycle past its acknowledge → no second access starts; `SramCE_n` stays high during `ERHOLUNG`.
- `ResetN` pulsed low during `SCHREIBEN_HOCH` → strobes high immediately, no acknowledge, FSM in `LEERLAUF`; a subsequent read completes normally.
- `WARTEZYKLEN=1` → read acknowledge after 5 cycles.

Source files
------------

// File: rtl/ram_steuerung_if.sv
// Cache-side RAM port of ram_steuerung: one 32-bit word request at a time,
// acknowledged by a one-cycle pulse.
interface ram_steuerung_if;
    logic        RAMLesen;
    logic        RAMSchreiben;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMSchreibDaten;
    logic [31:0] RAMLesDaten;
    logic        RAMDatenGeladen;
    logic        RAMDatenGelesen;

    modport master (
        output RAMLesen, RAMSchreiben, RAMAdresse, RAMSchreibDaten,
        input  RAMLesDaten, RAMDatenGeladen, RAMDatenGelesen
    );

    modport slave (
        input  RAMLesen, RAMSchreiben, RAMAdresse, RAMSchreibDaten,
        output RAMLesDaten, RAMDatenGeladen, RAMDatenGelesen
    );
endinterface

// File: rtl/ram_steuerung.sv
// Memory-side controller: splits one 32-bit cache request into two 16-bit
// asynchronous SRAM accesses with programmable wait states.
module ram_steuerung #(
    parameter int unsigned ADRBITS     = 19,
    parameter int unsigned WARTEZYKLEN = 2
) (
    input  logic               Takt,
    input  logic               ResetN,
    ram_steuerung_if.slave     cache,
    output logic [ADRBITS-1:0] SramAdresse,
    output logic [15:0]        SramDatenAus,
    input  logic [15:0]        SramDatenEin,
    output logic               SramDatenAusAktiv,
    output logic               SramCE_n,
    output logic               SramOE_n,
    output logic               SramWE_n
);

    localparam logic [3:0] PhaseEnde = 4'(WARTEZYKLEN);

    typedef enum logic [2:0] {
        LEERLAUF,
        LESEN_NIEDRIG,
        LESEN_HOCH,
        SCHREIBEN_NIEDRIG,
        SCHREIBEN_HOCH,
        FERTIG,
        ERHOLUNG
    } zustand_e;

    zustand_e zustand_q, zustand_d;
    logic [3:0] zaehler_q, zaehler_d;
    logic auftrag_q, auftrag_d;
    logic schreib_q, schreib_d;
    logic [ADRBITS-2:0] adr_q, adr_d;
    logic [31:0] wdaten_q, wdaten_d;
    logic [15:0] puffer_q, puffer_d;
    logic [31:0] les_daten_q, les_daten_d;
    logic geladen_q, geladen_d;
    logic gelesen_q, gelesen_d;
    logic [ADRBITS-1:0] sram_adr_q, sram_adr_d;
    logic [15:0] sram_dout_q, sram_dout_d;
    logic aktiv_q, aktiv_d;
    logic ce_n_q, ce_n_d;
    logic oe_n_q, oe_n_d;
    logic we_n_q, we_n_d;
    logic phase_ende;
    logic hw;
    logic unused_adr_bits;

    assign unused_adr_bits = ^{cache.RAMAdresse[1:0], cache.RAMAdresse[31:ADRBITS+1]};
    assign phase_ende = (zaehler_q == PhaseEnde);

    // State sequencing and request capture.
    always_comb begin
        zustand_d   = zustand_q;
        zaehler_d   = zaehler_q + 4'd1;
        auftrag_d   = auftrag_q;
        schreib_d   = schreib_q;
        adr_d       = adr_q;
        wdaten_d    = wdaten_q;
        puffer_d    = puffer_q;
        les_daten_d = les_daten_q;

        case (zustand_q)
            LEERLAUF: begin
                zaehler_d = '0;
                // Requests are registered first, the access starts on the next edge.
                if (auftrag_q) begin
                    zustand_d = schreib_q ? SCHREIBEN_NIEDRIG : LESEN_NIEDRIG;
                    auftrag_d = 1'b0;
                end else if (cache.RAMSchreiben || cache.RAMLesen) begin
                    auftrag_d = 1'b1;
                    schreib_d = cache.RAMSchreiben;
                    adr_d     = cache.RAMAdresse[ADRBITS:2];
                    wdaten_d  = cache.RAMSchreibDaten;
                end
            end
            LESEN_NIEDRIG: begin
                if (phase_ende) begin
                    zustand_d = LESEN_HOCH;
                    zaehler_d = '0;
                    puffer_d  = SramDatenEin;
                end
            end
            LESEN_HOCH: begin
                if (phase_ende) begin
                    zustand_d   = FERTIG;
                    zaehler_d   = '0;
                    les_daten_d = {SramDatenEin, puffer_q};
                end
            end
            SCHREIBEN_NIEDRIG: begin
                if (phase_ende) begin
                    zustand_d = SCHREIBEN_HOCH;
                    zaehler_d = '0;
                end
            end
            SCHREIBEN_HOCH: begin
                if (phase_ende) begin
                    zustand_d = FERTIG;
                    zaehler_d = '0;
                end
            end
            FERTIG: begin
                zustand_d = ERHOLUNG;
                zaehler_d = '0;
            end
            ERHOLUNG: begin
                zustand_d = LEERLAUF;
                zaehler_d = '0;
            end
            default: begin
                zustand_d = LEERLAUF;
                zaehler_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        aktiv_d     = 1'b0;
        sram_adr_d  = sram_adr_q;
        sram_dout_d = sram_dout_q;
        hw          = (zustand_d == LESEN_HOCH) || (zustand_d == SCHREIBEN_HOCH);
        geladen_d   = (zustand_d == FERTIG) && !schreib_q;
        gelesen_d   = (zustand_d == FERTIG) && schreib_q;

        case (zustand_d)
            LESEN_NIEDRIG, LESEN_HOCH: begin
                ce_n_d     = 1'b0;
                oe_n_d     = 1'b0;
                sram_adr_d = {adr_q, hw};
            end
            SCHREIBEN_NIEDRIG, SCHREIBEN_HOCH: begin
                ce_n_d      = 1'b0;
                aktiv_d     = 1'b1;
                // Last phase cycle keeps WE_n high for data hold.
                we_n_d      = (zaehler_d >= PhaseEnde);
                sram_adr_d  = {adr_q, hw};
                sram_dout_d = hw ? wdaten_q[31:16] : wdaten_q[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Takt or negedge ResetN) begin
        if (!ResetN) begin
            zustand_q   <= LEERLAUF;
            zaehler_q   <= '0;
            auftrag_q   <= 1'b0;
            schreib_q   <= 1'b0;
            adr_q       <= '0;
            wdaten_q    <= '0;
            puffer_q    <= '0;
            les_daten_q <= '0;
            geladen_q   <= 1'b0;
            gelesen_q   <= 1'b0;
            sram_adr_q  <= '0;
            sram_dout_q <= '0;
            aktiv_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            zustand_q   <= zustand_d;
            zaehler_q   <= zaehler_d;
            auftrag_q   <= auftrag_d;
            schreib_q   <= schreib_d;
            adr_q       <= adr_d;
            wdaten_q    <= wdaten_d;
            puffer_q    <= puffer_d;
            les_daten_q <= les_daten_d;
            geladen_q   <= geladen_d;
            gelesen_q   <= gelesen_d;
            sram_adr_q  <= sram_adr_d;
            sram_dout_q <= sram_dout_d;
            aktiv_q     <= aktiv_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign cache.RAMLesDaten     = les_daten_q;
    assign cache.RAMDatenGeladen = geladen_q;
    assign cache.RAMDatenGelesen = gelesen_q;
    assign SramAdresse           = sram_adr_q;
    assign SramDatenAus          = sram_dout_q;
    assign SramDatenAusAktiv     = aktiv_q;
    assign SramCE_n              = ce_n_q;
    assign SramOE_n              = oe_n_q;
    assign SramWE_n              = we_n_q;

endmodule

// File: tb/tb_ram_steuerung.sv
// Bench for ram_steuerung: two instances (2 and 1 wait cycles) with behavioural
// SRAM models and queue-based scoreboards for SRAM writes and read data.
module tb_ram_steuerung;

    localparam int unsigned ADRB = 19;

    logic Takt;
    logic ResetN;

    ram_steuerung_if cif_a ();
    ram_steuerung_if cif_b ();

    logic [ADRB-1:0] adr_a, adr_b;
    logic [15:0]     dout_a, dout_b, din_a, din_b;
    logic            aktiv_a, aktiv_b;
    logic            ce_n_a, oe_n_a, we_n_a;
    logic            ce_n_b, oe_n_b, we_n_b;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];

    logic [ADRB+15:0] exp_wr_a [$];
    logic [31:0]      exp_rd_a [$];
    logic [31:0]      exp_rd_b [$];

    int n_tests = 0;
    int n_fail = 0;
    int n_ack_a = 0;
    int n_ack_b = 0;
    int we_cnt_a = 0;
    bit gel_a, ges_a, gel_b, ges_b;

    assign din_a = (!ce_n_a && !oe_n_a) ? mem_a[adr_a[9:0]] : 16'h0000;
    assign din_b = (!ce_n_b && !oe_n_b) ? mem_b[adr_b[9:0]] : 16'h0000;

    ram_steuerung #(.ADRBITS(ADRB), .WARTEZYKLEN(2)) dut_a (
        .Takt              (Takt),
        .ResetN            (ResetN),
        .cache             (cif_a),
        .SramAdresse       (adr_a),
        .SramDatenAus      (dout_a),
        .SramDatenEin      (din_a),
        .SramDatenAusAktiv (aktiv_a),
        .SramCE_n          (ce_n_a),
        .SramOE_n          (oe_n_a),
        .SramWE_n          (we_n_a)
    );

    ram_steuerung #(.ADRBITS(ADRB), .WARTEZYKLEN(1)) dut_b (
        .Takt              (Takt),
        .ResetN            (ResetN),
        .cache             (cif_b),
        .SramAdresse       (adr_b),
        .SramDatenAus      (dout_b),
        .SramDatenEin      (din_b),
        .SramDatenAusAktiv (aktiv_b),
        .SramCE_n          (ce_n_b),
        .SramOE_n          (oe_n_b),
        .SramWE_n          (we_n_b)
    );

    initial Takt = 1'b0;
    always #5 Takt = ~Takt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: SRAM models, write-phase monitor and read scoreboard, sampled at negedge.
    task automatic tick();
        @(negedge Takt);
        if (!ce_n_a && !we_n_a) begin
            mem_a[adr_a[9:0]] = dout_a;
            we_cnt_a++;
        end
        if (!ce_n_b && !we_n_b) mem_b[adr_b[9:0]] = dout_b;
        if (!ce_n_a && aktiv_a && we_n_a) begin
            if (exp_wr_a.size() == 0) begin
                check("a sram write unexpected", 64'(exp_wr_a.size()), 64'd1);
            end else begin
                check("a sram write adr/data", 64'({adr_a, dout_a}), 64'(exp_wr_a.pop_front()));
                check("a we_n low cycles", 64'(we_cnt_a), 64'd2);
            end
            we_cnt_a = 0;
        end
        gel_a = cif_a.RAMDatenGeladen;
        ges_a = cif_a.RAMDatenGelesen;
        gel_b = cif_b.RAMDatenGeladen;
        ges_b = cif_b.RAMDatenGelesen;
        if (gel_a) begin
            n_ack_a++;
            if (exp_rd_a.size() == 0) check("a read unexpected", 64'(exp_rd_a.size()), 64'd1);
            else check("a read data", 64'(cif_a.RAMLesDaten), 64'(exp_rd_a.pop_front()));
        end
        if (ges_a) n_ack_a++;
        if (gel_b) begin
            n_ack_b++;
            if (exp_rd_b.size() == 0) check("b read unexpected", 64'(exp_rd_b.size()), 64'd1);
            else check("b read data", 64'(cif_b.RAMLesDaten), 64'(exp_rd_b.pop_front()));
        end
        if (ges_b) n_ack_b++;
    endtask

    task automatic erwarte_schreiben(input logic [31:0] adr, input logic [31:0] dat);
        exp_wr_a.push_back({adr[ADRB:2], 1'b0, dat[15:0]});
        exp_wr_a.push_back({adr[ADRB:2], 1'b1, dat[31:16]});
    endtask

    task automatic pruefe_reset(input string tag);
        check({tag, " RAMLesDaten"}, 64'(cif_a.RAMLesDaten), 64'd0);
        check({tag, " Geladen"}, 64'(cif_a.RAMDatenGeladen), 64'd0);
        check({tag, " Gelesen"}, 64'(cif_a.RAMDatenGelesen), 64'd0);
        check({tag, " CE_n"}, 64'(ce_n_a), 64'd1);
        check({tag, " OE_n"}, 64'(oe_n_a), 64'd1);
        check({tag, " WE_n"}, 64'(we_n_a), 64'd1);
        check({tag, " AusAktiv"}, 64'(aktiv_a), 64'd0);
        check({tag, " SramAdresse"}, 64'(adr_a), 64'd0);
        check({tag, " SramDatenAus"}, 64'(dout_a), 64'd0);
    endtask

    // Cache-side request: hold until acknowledge (plus extra cycles), then drop.
    task automatic anfrage(input bit b, input bit schreib, input logic [31:0] adr,
                           input logic [31:0] dat, input int extra, input string tag);
        int lat;
        bit seen;
        if (b) begin
            cif_b.RAMAdresse = adr;
            cif_b.RAMLesen   = 1'b1;
        end else begin
            cif_a.RAMAdresse      = adr;
            cif_a.RAMSchreibDaten = dat;
            cif_a.RAMSchreiben    = schreib;
            cif_a.RAMLesen        = !schreib;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            tick();
            lat++;
            seen = b ? gel_b : (schreib ? ges_a : gel_a);
        end
        check({tag, " ack"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat - 1), b ? 64'd5 : 64'd7);
        for (int i = 0; i < extra; i++) begin
            tick();
            check({tag, " CE_n in recovery"}, 64'(ce_n_a), 64'd1);
        end
        cif_a.RAMLesen     = 1'b0;
        cif_a.RAMSchreiben = 1'b0;
        cif_b.RAMLesen     = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int n0;
        int lat;
        int n_ce;
        ResetN                = 1'b0;
        cif_a.RAMLesen        = 1'b0;
        cif_a.RAMSchreiben    = 1'b0;
        cif_a.RAMAdresse      = '0;
        cif_a.RAMSchreibDaten = '0;
        cif_b.RAMLesen        = 1'b0;
        cif_b.RAMSchreiben    = 1'b0;
        cif_b.RAMAdresse      = '0;
        cif_b.RAMSchreibDaten = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_b[10'h082] = 16'hBEEF;
        mem_b[10'h083] = 16'hDEAD;

        repeat (3) tick();
        pruefe_reset("reset");
        check("b RAMLesDaten reset", 64'(cif_b.RAMLesDaten), 64'd0);
        ResetN = 1'b1;
        repeat (5) tick();
        pruefe_reset("idle 5 clocks");

        n0 = n_ack_a;
        erwarte_schreiben(32'h0000_0104, 32'hDEAD_BEEF);
        anfrage(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, "wr 104");
        check("wr 104 sram writes left", 64'(exp_wr_a.size()), 64'd0);
        check("wr 104 ack count", 64'(n_ack_a - n0), 64'd1);

        exp_rd_a.push_back(32'hDEAD_BEEF);
        anfrage(1'b0, 1'b0, 32'h0000_0104, 32'h0, 0, "rd 104");
        check("rd 104 scoreboard empty", 64'(exp_rd_a.size()), 64'd0);

        erwarte_schreiben(32'h0000_0108, 32'h1234_5678);
        anfrage(1'b0, 1'b1, 32'h0000_0108, 32'h1234_5678, 0, "wr 108");
        check("RAMLesDaten held over write", 64'(cif_a.RAMLesDaten), 64'hDEAD_BEEF);

        // Bits above ADRBITS+1 wrap onto the same SRAM word.
        exp_rd_a.push_back(32'h1234_5678);
        anfrage(1'b0, 1'b0, 32'hFFF0_0108, 32'h0, 0, "rd wrap");
        check("rd wrap scoreboard empty", 64'(exp_rd_a.size()), 64'd0);

        n0 = n_ack_a;
        erwarte_schreiben(32'h0000_0110, 32'hCAFE_F00D);
        exp_rd_a.push_back(32'hCAFE_F00D);
        cif_a.RAMAdresse      = 32'h0000_0110;
        cif_a.RAMSchreibDaten = 32'hCAFE_F00D;
        cif_a.RAMSchreiben    = 1'b1;
        cif_a.RAMLesen        = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ges_a && !gel_a && lat < 60);
        check("both first ack is write", 64'(ges_a), 64'd1);
        check("both write latency", 64'(lat - 1), 64'd7);
        cif_a.RAMSchreiben = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!gel_a && lat < 60);
        check("both read ack", 64'(gel_a), 64'd1);
        cif_a.RAMLesen = 1'b0;
        repeat (10) tick();
        check("both ack count", 64'(n_ack_a - n0), 64'd2);
        check("both sram writes left", 64'(exp_wr_a.size()), 64'd0);
        check("both reads left", 64'(exp_rd_a.size()), 64'd0);

        n0 = n_ack_a;
        exp_rd_a.push_back(32'h1234_5678);
        anfrage(1'b0, 1'b0, 32'h0000_0108, 32'h0, 1, "rd held");
        n_ce = 0;
        repeat (12) begin
            tick();
            if (!ce_n_a) n_ce++;
        end
        check("held no second access", 64'(n_ce), 64'd0);
        check("held ack count", 64'(n_ack_a - n0), 64'd1);

        erwarte_schreiben(32'h0000_0200, 32'h55AA_33CC);
        cif_a.RAMAdresse      = 32'h0000_0200;
        cif_a.RAMSchreibDaten = 32'h55AA_33CC;
        cif_a.RAMSchreiben    = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(!ce_n_a && aktiv_a && adr_a[0]) && lat < 30);
        check("rst reached write high phase", 64'(!ce_n_a && aktiv_a && adr_a[0]), 64'd1);
        ResetN = 1'b0;
        #1;
        pruefe_reset("mid-access reset");
        cif_a.RAMSchreiben = 1'b0;
        exp_wr_a.delete();
        we_cnt_a = 0;
        n0 = n_ack_a;
        repeat (2) tick();
        ResetN = 1'b1;
        repeat (8) tick();
        check("rst no ack", 64'(n_ack_a - n0), 64'd0);
        exp_rd_a.push_back(32'hDEAD_BEEF);
        anfrage(1'b0, 1'b0, 32'h0000_0104, 32'h0, 0, "rd after reset");

        exp_rd_b.push_back(32'hDEAD_BEEF);
        anfrage(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, "b rd 104");
        check("b reads left", 64'(exp_rd_b.size()), 64'd0);
        check("b ack count", 64'(n_ack_b), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
